pipe_perf_monitor: RTL and testbench

- Synthesizable performance-event monitor for the pipelined CPU. Counts run cycles plus NUM_EVT event strobes such as stall, flush, retired instruction and branch-taken.
- Supports a programmable cycle limit, a freeze mode, sticky overflow flags and a registered read port.
- Sits beside the CPU top level. Event strobes are taken from hazard detection, flush logic and write-back, so the counts are available in silicon and not only in simulation.

---
 rtl/perf_pkg.sv | 24 ++
 rtl/perf_counter.sv | 39 +++
 rtl/pipe_perf_monitor.sv | 123 ++++++++++++
 tb/tb_pipe_perf_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package perf_pkg;

    // Monitor run state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Event channel assignment as wired at the CPU top level
    localparam int EVT_STALL  = 0;
    localparam int EVT_FLUSH  = 1;
    localparam int EVT_RETIRE = 2;
    localparam int EVT_BRANCH = 3;

    // Default counter width and run length
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_CYCLE_LIMIT = 70;

endpackage

// File: rtl/perf_counter.sv
// One event counter with saturate-or-wrap overflow and a sticky overflow flag.
// Latency: an increment sampled at an edge is visible right after that edge.
// Backpressure: none; inc_i is a per-cycle strobe and is always accepted.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    // Count, holding or wrapping at all-ones; overflow flag stays set until cleared
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (inc_i) begin
            if (&r_cnt) begin
                r_ovf <= 1'b1;
                r_cnt <= SATURATE ? r_cnt : '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cnt_o = r_cnt;
    assign ovf_o = r_ovf;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Performance-event monitor: run-cycle counter plus NUM_EVT event counters with limit/freeze.
// Latency: counters update the edge an event is sampled; rd_data_o follows one edge later.
// Backpressure: none; strobes are sampled every cycle, counting pauses only via freeze/state.
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT     = 4,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
    parameter bit SATURATE    = 1'b1,
    localparam int SEL_W      = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               freeze_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [NUM_EVT-1:0] ovf_o,
    output logic               running_o,
    output logic               done_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

    state_t           r_state;
    logic             r_running;
    logic             r_done;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_rd_data;

    logic             w_clr;
    logic             w_inc;
    logic [CNT_W-1:0] w_cycle_nxt;
    logic [CNT_W-1:0] w_cnt [NUM_EVT];
    logic [NUM_EVT-1:0] w_ovf;

    assign w_clr       = rst_i || clear_i;
    // Counting happens only on a RUN cycle that is not leaving RUN
    assign w_inc       = (r_state == ST_RUN) && start_i && !freeze_i;
    assign w_cycle_nxt = r_cycle + CNT_W'(1);

    // Run-state machine and cycle counter; running/done are registered with the state
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_cycle   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state   <= freeze_i ? ST_FROZEN : ST_RUN;
                        r_running <= !freeze_i;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end else if (freeze_i) begin
                        r_state   <= ST_FROZEN;
                        r_running <= 1'b0;
                    end else begin
                        r_cycle <= w_cycle_nxt;
                        // The final cycle's events are still counted by the channels
                        if (CYCLE_LIMIT != 0 && w_cycle_nxt == LIMIT) begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (!freeze_i) begin
                        r_state   <= start_i ? ST_RUN : ST_IDLE;
                        r_running <= start_i;
                    end
                end
                default: begin
                    // DONE is left only through reset or clear
                end
            endcase
        end
    end

    // Event counter channels
    for (genvar k = 0; k < NUM_EVT; k++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (w_inc && evt_i[k]),
            .cnt_o (w_cnt[k]),
            .ovf_o (w_ovf[k])
        );
    end

    // Registered read port; out-of-range selects read as zero
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_rd_data <= '0;
        end else if (int'(sel_i) < NUM_EVT) begin
            r_rd_data <= w_cnt[sel_i];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign rd_data_o = r_rd_data;
    assign cycle_o   = r_cycle;
    assign ovf_o     = w_ovf;
    assign running_o = r_running;
    assign done_o    = r_done;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: four configurations share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed
// scenario checks against hand-computed values.
module tb_pipe_perf_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] evt = 4'd0;
    logic [1:0] sel = 2'd0;

    always #5 clk = ~clk;

    // d0: 4 ch, 32b, limit 70, saturate
    logic [31:0] rd0, cyc0;
    logic [3:0]  ovf0;
    logic        run0, done0;
    // d1: 4 ch, 4b, unlimited, saturate
    logic [3:0]  rd1, cyc1, ovf1;
    logic        run1, done1;
    // d2: 4 ch, 4b, unlimited, wrap
    logic [3:0]  rd2, cyc2, ovf2;
    logic        run2, done2;
    // d3: 3 ch, 8b, limit 20, wrap
    logic [7:0]  rd3, cyc3;
    logic [2:0]  ovf3;
    logic        run3, done3;

    pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .CYCLE_LIMIT(70), .SATURATE(1'b1)) u_d0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .evt_i(evt), .sel_i(sel), .rd_data_o(rd0), .cycle_o(cyc0), .ovf_o(ovf0),
        .running_o(run0), .done_o(done0));
    pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .CYCLE_LIMIT(0), .SATURATE(1'b1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .evt_i(evt), .sel_i(sel), .rd_data_o(rd1), .cycle_o(cyc1), .ovf_o(ovf1),
        .running_o(run1), .done_o(done1));
    pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .CYCLE_LIMIT(0), .SATURATE(1'b0)) u_d2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .evt_i(evt), .sel_i(sel), .rd_data_o(rd2), .cycle_o(cyc2), .ovf_o(ovf2),
        .running_o(run2), .done_o(done2));
    pipe_perf_monitor #(.NUM_EVT(3), .CNT_W(8), .CYCLE_LIMIT(20), .SATURATE(1'b0)) u_d3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .evt_i(evt[2:0]), .sel_i(sel), .rd_data_o(rd3), .cycle_o(cyc3), .ovf_o(ovf3),
        .running_o(run3), .done_o(done3));

    // Model configuration per instance
    int nevt [4] = '{4, 4, 4, 3};
    int cw   [4] = '{32, 4, 4, 8};
    int lim  [4] = '{70, 0, 0, 20};
    int sat  [4] = '{1, 1, 0, 0};

    // Model state: mode 0=idle 1=run 2=frozen 3=done
    int     mode [4];
    longint mcyc [4];
    longint mrd  [4];
    longint mcnt [4][4];
    bit     movf [4][4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of the monitor's rules, applied with the inputs present at the edge
    task automatic model_step();
        for (int d = 0; d < 4; d++) begin
            longint mx;
            mx = (64'd1 << cw[d]) - 1;
            if (rst || clear) begin
                mode[d] = 0;
                mcyc[d] = 0;
                mrd[d]  = 0;
                for (int k = 0; k < 4; k++) begin
                    mcnt[d][k] = 0;
                    movf[d][k] = 1'b0;
                end
            end else begin
                mrd[d] = (int'(sel) < nevt[d]) ? mcnt[d][sel] : 0;
                case (mode[d])
                    0: if (start) mode[d] = freeze ? 2 : 1;
                    1: begin
                        if (!start) mode[d] = 0;
                        else if (freeze) mode[d] = 2;
                        else begin
                            mcyc[d] = (mcyc[d] + 1) & mx;
                            for (int k = 0; k < nevt[d]; k++) begin
                                if (evt[k]) begin
                                    if (mcnt[d][k] == mx) begin
                                        movf[d][k] = 1'b1;
                                        mcnt[d][k] = (sat[d] != 0) ? mx : 0;
                                    end else begin
                                        mcnt[d][k] = mcnt[d][k] + 1;
                                    end
                                end
                            end
                            if (lim[d] != 0 && mcyc[d] == lim[d]) mode[d] = 3;
                        end
                    end
                    2: if (!freeze) mode[d] = start ? 1 : 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        longint oc [4];
        longint orr [4];
        longint oo [4];
        longint orun [4];
        longint odn [4];
        longint eo;
        oc[0] = cyc0; oc[1] = cyc1; oc[2] = cyc2; oc[3] = cyc3;
        orr[0] = rd0; orr[1] = rd1; orr[2] = rd2; orr[3] = rd3;
        oo[0] = ovf0; oo[1] = ovf1; oo[2] = ovf2; oo[3] = ovf3;
        orun[0] = run0; orun[1] = run1; orun[2] = run2; orun[3] = run3;
        odn[0] = done0; odn[1] = done1; odn[2] = done2; odn[3] = done3;
        for (int d = 0; d < 4; d++) begin
            eo = 0;
            for (int k = 0; k < nevt[d]; k++) eo |= longint'(movf[d][k]) << k;
            chk($sformatf("d%0d_cycle", d), oc[d], mcyc[d]);
            chk($sformatf("d%0d_rd_data", d), orr[d], mrd[d]);
            chk($sformatf("d%0d_ovf", d), oo[d], eo);
            chk($sformatf("d%0d_running", d), orun[d], longint'(mode[d] == 1));
            chk($sformatf("d%0d_done", d), odn[d], longint'(mode[d] == 3));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic do_clear();
        start = 1'b0; freeze = 1'b0; evt = 4'd0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    int exp_rd [4] = '{12, 7, 0, 3};

    initial begin
        // Power-on reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("reset_cycle", cyc0, 0);
        chk("reset_running", run0, 0);

        // Reset mid-run
        start = 1'b1; evt = 4'b1111;
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; start = 1'b0; evt = 4'd0;
        chk("midrun_rst_cycle", cyc0, 0);
        chk("midrun_rst_ovf", ovf0, 0);
        chk("midrun_rst_running", run0, 0);

        // Freeze: 5 counted cycles, 8 frozen, 3 counted
        do_clear();
        start = 1'b1;
        tick(1);
        evt = 4'b0011;
        tick(5);
        freeze = 1'b1;
        tick(8);
        chk("frozen_cycle", cyc0, 5);
        freeze = 1'b0;
        tick(1);
        tick(3);
        chk("freeze_cycle", cyc0, 8);
        start = 1'b0; evt = 4'd0;
        tick(1);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick(1);
            chk($sformatf("freeze_cnt%0d", s), rd0, (s < 2) ? 8 : 0);
        end

        // Cycle limit: events on alternate cycles, then extra events after DONE
        do_clear();
        start = 1'b1;
        tick(1);
        for (int i = 0; i < 70; i++) begin
            evt = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick(1);
        end
        chk("limit_done", done0, 1);
        chk("limit_cycle", cyc0, 70);
        evt = 4'b1111;
        tick(20);
        chk("limit_hold_cycle", cyc0, 70);
        chk("limit_hold_done", done0, 1);
        evt = 4'd0; sel = 2'd0;
        tick(1);
        chk("limit_cnt0", rd0, 35);

        // Saturate vs wrap on 4-bit counters
        do_clear();
        start = 1'b1;
        tick(1);
        evt = 4'b0001;
        tick(20);
        start = 1'b0; evt = 4'd0; sel = 2'd0;
        tick(1);
        chk("sat_cnt0", rd1, 15);
        chk("sat_ovf0", ovf1[0], 1);
        chk("wrap_cnt0", rd2, 4);
        chk("wrap_ovf0", ovf2[0], 1);

        // Clear has priority over events while running
        start = 1'b1;
        tick(1);
        evt = 4'b1111; clear = 1'b1;
        tick(1);
        chk("clear_running", run0, 0);
        chk("clear_cycle", cyc0, 0);
        chk("clear_ovf", ovf1, 0);
        clear = 1'b0;
        tick(1);
        chk("clear_rerun_running", run0, 1);
        chk("clear_rerun_cycle", cyc0, 0);
        tick(1);
        chk("clear_first_count", cyc0, 1);

        // Read port sweep with counters {12,7,0,3}
        do_clear();
        start = 1'b1;
        tick(1);
        for (int i = 0; i < 12; i++) begin
            evt = {(i < 3), 1'b0, (i < 7), 1'b1};
            tick(1);
        end
        start = 1'b0; evt = 4'd0;
        tick(1);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick(1);
            chk($sformatf("rdport_sel%0d", s), rd0, exp_rd[s]);
        end
        chk("rdport_out_of_range", rd3, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            clear  = ($urandom_range(0, 49) == 0);
            start  = ($urandom_range(0, 7) != 0);
            freeze = ($urandom_range(0, 7) == 0);
            evt    = 4'($urandom);
            sel    = 2'($urandom);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
